// File: rtl/prog_host_pkg.sv
// Shared types and default parameters for the prog_host run-handshake initiator.
package prog_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_BLANK,
    ST_RUN,
    ST_DONE
  } host_state_t;

  localparam int NPROG_D   = 3;
  localparam int CW_D      = 16;
  localparam int TIMEOUT_D = 20000;
  localparam int BLANK_D   = 2;

  // Width of the program index; never narrower than one bit.
  function automatic int sel_width(input int nprog);
    return (nprog > 1) ? $clog2(nprog) : 1;
  endfunction

endpackage

// File: rtl/prog_host_run_timer.sv
// Up-counter with synchronous clear, count enable and a fixed terminal-count compare.
module run_timer #(
  parameter int            CW   = 16,
  parameter logic [CW-1:0] TERM = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc
);

  // Count register: clear wins over enable so a new phase always starts at zero.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == TERM);

endmodule

// File: rtl/prog_host.sv
// Launches NPROG programs on the core one after another, timing each run and flagging timeouts.
module prog_host
  import prog_host_pkg::*;
#(
  parameter int NPROG   = NPROG_D,
  parameter int CW      = CW_D,
  parameter int TIMEOUT = TIMEOUT_D,
  parameter int BLANK   = BLANK_D
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        ack,
  output logic                        req,
  output logic [sel_width(NPROG)-1:0] prog_sel,
  output logic                        busy,
  output logic                        cyc_valid,
  output logic [CW-1:0]               cycles,
  output logic                        done,
  output logic                        timeout_err
);

  localparam int            SW   = sel_width(NPROG);
  localparam logic [SW-1:0] LAST = SW'(NPROG - 1);

  host_state_t   state_q;
  host_state_t   next_state;
  logic [SW-1:0] cur_idx;
  logic          launch;
  logic          capture;
  logic          timed_out;
  logic          blank_clr;
  logic          blank_en;
  logic          blank_tc;
  logic          run_clr;
  logic          run_en;
  logic          run_tc;
  logic [CW-1:0] run_count;
  // BLANK only needs the terminal count; the raw count is not used.
  logic [CW-1:0] blank_count_unused;

  run_timer #(
    .CW  (CW),
    .TERM(CW'(BLANK - 1))
  ) u_blank_timer (
    .clk  (clk),
    .reset(reset),
    .clear(blank_clr),
    .en   (blank_en),
    .count(blank_count_unused),
    .tc   (blank_tc)
  );

  run_timer #(
    .CW  (CW),
    .TERM(CW'(TIMEOUT))
  ) u_run_timer (
    .clk  (clk),
    .reset(reset),
    .clear(run_clr),
    .en   (run_en),
    .count(run_count),
    .tc   (run_tc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  // Next state and per-cycle control strobes; ack beats the timeout on the terminal cycle.
  always_comb begin
    next_state = state_q;
    launch     = 1'b0;
    capture    = 1'b0;
    timed_out  = 1'b0;
    blank_clr  = 1'b1;
    blank_en   = 1'b0;
    run_clr    = 1'b1;
    run_en     = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          next_state = ST_REQ;
          launch     = 1'b1;
        end
      end
      ST_REQ: begin
        next_state = ST_BLANK;
      end
      ST_BLANK: begin
        blank_clr = 1'b0;
        blank_en  = 1'b1;
        if (blank_tc) begin
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        run_clr = 1'b0;
        if (ack) begin
          capture    = 1'b1;
          next_state = (cur_idx == LAST) ? ST_DONE : ST_REQ;
        end else if (run_tc) begin
          capture    = 1'b1;
          timed_out  = 1'b1;
          next_state = ST_DONE;
        end else begin
          run_en = 1'b1;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Registered outputs, program index and result capture; prog_sel lags cur_idx by one cycle so it names the finished program while cyc_valid is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      req         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cyc_valid   <= 1'b0;
      timeout_err <= 1'b0;
      prog_sel    <= '0;
      cur_idx     <= '0;
      cycles      <= '0;
    end else begin
      req       <= (next_state == ST_REQ);
      busy      <= (next_state inside {ST_REQ, ST_BLANK, ST_RUN});
      done      <= (next_state == ST_DONE);
      cyc_valid <= capture;
      prog_sel  <= launch ? '0 : cur_idx;
      if (launch) begin
        cur_idx <= '0;
      end else if (capture && next_state == ST_REQ) begin
        cur_idx <= cur_idx + 1'b1;
      end
      if (capture) begin
        cycles <= timed_out ? CW'(TIMEOUT) : run_count;
      end
      if (launch) begin
        timeout_err <= 1'b0;
      end else if (timed_out) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prog_host.sv
// Self-checking bench for prog_host: cycle model plus directed sequences with literal expectations.
module tb_prog_host;

  localparam int NPROG   = 3;
  localparam int CW      = 16;
  localparam int TIMEOUT = 50;
  localparam int BLANK   = 2;
  localparam int BUDGET  = 200;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          ack = 1'b0;
  logic          req;
  logic [1:0]    prog_sel;
  logic          busy;
  logic          cyc_valid;
  logic [CW-1:0] cycles;
  logic          done;
  logic          timeout_err;

  int tests = 0;
  int fails = 0;
  int req_count = 0;
  int delays[$];

  bit   model_ok = 1'b0;
  bit   m_active = 1'b0;
  int   m_pos = 0;
  int   m_run = 0;
  int   m_prog = 0;
  logic e_req = 1'b0;
  logic e_busy = 1'b0;
  logic e_done = 1'b0;
  logic e_cv = 1'b0;
  logic e_terr = 1'b0;
  int   e_sel = 0;
  int   e_cycles = 0;

  prog_host #(
    .NPROG  (NPROG),
    .CW     (CW),
    .TIMEOUT(TIMEOUT),
    .BLANK  (BLANK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ack        (ack),
    .req        (req),
    .prog_sel   (prog_sel),
    .busy       (busy),
    .cyc_valid  (cyc_valid),
    .cycles     (cycles),
    .done       (done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pulse start for one sampling edge after the given number of clock edges.
  task automatic applyStimulus(input int wait_cycles);
    repeat (wait_cycles) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitCycValid(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (cyc_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("[TB] FAIL %s: no cyc_valid within %0d cycles", name, BUDGET);
    end
  endtask

  // Core model: after each req, ack drops on the first RUN cycle and rises d RUN cycles later (d<0: never, d=0: stays high).
  initial begin
    int d;
    forever begin
      @(negedge clk);
      if (req === 1'b1) begin
        d = (delays.size() > 0) ? delays.pop_front() : 10;
        repeat (BLANK + 1) @(posedge clk);
        #1;
        if (d == 0) begin
          ack = 1'b1;
        end else begin
          ack = 1'b0;
          if (d > 0) begin
            repeat (d) @(posedge clk);
            #1 ack = 1'b1;
          end
        end
      end
    end
  end

  // Reference model: tracks position relative to the last req and the count of ack-low RUN cycles.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        model_ok = 1'b1;
        m_active = 1'b0;
        m_pos = 0;
        m_run = 0;
        m_prog = 0;
        e_req = 1'b0;
        e_busy = 1'b0;
        e_done = 1'b0;
        e_cv = 1'b0;
        e_terr = 1'b0;
        e_sel = 0;
        e_cycles = 0;
      end else begin
        e_req = 1'b0;
        e_cv = 1'b0;
        if (!m_active) begin
          if (start) begin
            m_active = 1'b1;
            m_pos = 0;
            m_run = 0;
            m_prog = 0;
            e_sel = 0;
            e_terr = 1'b0;
            e_req = 1'b1;
            e_busy = 1'b1;
            e_done = 1'b0;
          end
        end else if (m_pos <= BLANK) begin
          m_pos++;
          e_sel = m_prog;
        end else if (ack || m_run == TIMEOUT) begin
          e_cv = 1'b1;
          e_cycles = m_run;
          e_sel = m_prog;
          if (!ack) e_terr = 1'b1;
          if (!ack || m_prog == NPROG - 1) begin
            m_active = 1'b0;
            e_busy = 1'b0;
            e_done = 1'b1;
          end else begin
            m_prog++;
            m_pos = 0;
            m_run = 0;
            e_req = 1'b1;
          end
        end else begin
          m_run++;
          e_sel = m_prog;
        end
      end
    end
  end

  // Per-cycle compare of every output against the model, plus req pulse counting.
  initial begin
    forever begin
      @(negedge clk);
      if (req === 1'b1) req_count++;
      if (model_ok) begin
        checkOutput("model_req", {31'd0, req}, {31'd0, e_req});
        checkOutput("model_busy", {31'd0, busy}, {31'd0, e_busy});
        checkOutput("model_done", {31'd0, done}, {31'd0, e_done});
        checkOutput("model_cyc_valid", {31'd0, cyc_valid}, {31'd0, e_cv});
        checkOutput("model_timeout_err", {31'd0, timeout_err}, {31'd0, e_terr});
        checkOutput("model_prog_sel", {30'd0, prog_sel}, e_sel);
        checkOutput("model_cycles", {16'd0, cycles}, e_cycles);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;

    // Reset state.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_req", {31'd0, req}, 0);
    checkOutput("rst_busy", {31'd0, busy}, 0);
    checkOutput("rst_done", {31'd0, done}, 0);
    checkOutput("rst_cyc_valid", {31'd0, cyc_valid}, 0);
    checkOutput("rst_timeout_err", {31'd0, timeout_err}, 0);
    checkOutput("rst_prog_sel", {30'd0, prog_sel}, 0);
    checkOutput("rst_cycles", {16'd0, cycles}, 0);

    // Sequence A: three programs, each acks after 10 RUN cycles.
    base = req_count;
    delays = {10, 10, 10};
    applyStimulus(1);
    @(negedge clk);
    checkOutput("a_req_after_start", {31'd0, req}, 1);
    for (int p = 0; p < 3; p++) begin
      waitCycValid($sformatf("a_cv%0d", p));
      checkOutput($sformatf("a_cycles%0d", p), {16'd0, cycles}, 10);
      checkOutput($sformatf("a_sel%0d", p), {30'd0, prog_sel}, p);
    end
    checkOutput("a_done", {31'd0, done}, 1);
    checkOutput("a_terr", {31'd0, timeout_err}, 0);
    checkOutput("a_reqs", req_count - base, 3);

    // Sequence B: ack still high from A through REQ/BLANK; start pulsed mid-RUN; ack on terminal count.
    repeat (4) @(negedge clk);
    base = req_count;
    delays = {5, 50, 0};
    applyStimulus(1);
    applyStimulus(3);
    waitCycValid("b_cv0");
    checkOutput("b_cycles0", {16'd0, cycles}, 5);
    checkOutput("b_sel0", {30'd0, prog_sel}, 0);
    waitCycValid("b_cv1");
    checkOutput("b_cycles1", {16'd0, cycles}, TIMEOUT);
    checkOutput("b_terr1", {31'd0, timeout_err}, 0);
    checkOutput("b_done1", {31'd0, done}, 0);
    checkOutput("b_req1", {31'd0, req}, 1);
    waitCycValid("b_cv2");
    checkOutput("b_cycles2", {16'd0, cycles}, 0);
    checkOutput("b_sel2", {30'd0, prog_sel}, 2);
    checkOutput("b_done2", {31'd0, done}, 1);
    checkOutput("b_reqs", req_count - base, 3);

    // Sequence C: program 1 never acks.
    base = req_count;
    delays = {10, -1, 10};
    applyStimulus(2);
    waitCycValid("c_cv0");
    checkOutput("c_cycles0", {16'd0, cycles}, 10);
    waitCycValid("c_cv1");
    checkOutput("c_cycles1", {16'd0, cycles}, TIMEOUT);
    checkOutput("c_terr", {31'd0, timeout_err}, 1);
    checkOutput("c_done", {31'd0, done}, 1);
    checkOutput("c_sel", {30'd0, prog_sel}, 1);
    repeat (20) @(negedge clk);
    checkOutput("c_reqs", req_count - base, 2);
    checkOutput("c_terr_sticky", {31'd0, timeout_err}, 1);
    checkOutput("c_busy", {31'd0, busy}, 0);

    // Sequence D: relaunch from DONE clears timeout_err, then reset in the middle of program 2.
    delays = {10, 10, 10};
    applyStimulus(1);
    @(negedge clk);
    checkOutput("d_req", {31'd0, req}, 1);
    checkOutput("d_terr_cleared", {31'd0, timeout_err}, 0);
    checkOutput("d_sel", {30'd0, prog_sel}, 0);
    checkOutput("d_busy", {31'd0, busy}, 1);
    waitCycValid("d_cv0");
    waitCycValid("d_cv1");
    checkOutput("d_sel1", {30'd0, prog_sel}, 1);
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("d_rst_req", {31'd0, req}, 0);
    checkOutput("d_rst_busy", {31'd0, busy}, 0);
    checkOutput("d_rst_done", {31'd0, done}, 0);
    checkOutput("d_rst_sel", {30'd0, prog_sel}, 0);
    checkOutput("d_rst_cycles", {16'd0, cycles}, 0);
    repeat (15) @(negedge clk);
    checkOutput("d_idle_busy", {31'd0, busy}, 0);
    checkOutput("d_idle_cv", {31'd0, cyc_valid}, 0);

    // Restart after reset.
    delays = {3, 3, 3};
    applyStimulus(1);
    waitCycValid("e_cv0");
    checkOutput("e_sel0", {30'd0, prog_sel}, 0);
    checkOutput("e_cycles0", {16'd0, cycles}, 3);
    waitCycValid("e_cv1");
    waitCycValid("e_cv2");
    checkOutput("e_done", {31'd0, done}, 1);
    checkOutput("e_sel2", {30'd0, prog_sel}, 2);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
